axi_sram_slave: RTL

Single-port AXI responder that serves the CPU's data-side AXI master, which issues load/store transfers from the memory stage, out of a synchronous 1-cycle-latency data SRAM. Handles one outstanding transaction at a time: single-beat reads (AR→R) and single-beat writes (AW+W→B). Sits between the CPU AXI data port and the data SRAM macro, replacing the direct data_sram_* connection.

---
 rtl/axi_slv_pkg.sv | 26 ++
 rtl/axi_sram_slave.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/axi_slv_pkg.sv
// axi_slv_pkg: shared types and constants for the
// data-side AXI-to-SRAM responder.
package axi_slv_pkg;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_RD_DATA    = 3'd1,
      ST_R_RESP     = 3'd2,
      ST_WR_COLLECT = 3'd3,
      ST_WR_SRAM    = 3'd4,
      ST_B_RESP     = 3'd5
   } state_t;

   localparam int NUM_STATES = 6;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // Byte address to SRAM word address (drops the lane bits).
   function automatic logic [29:0] byte_to_word(
      input logic [31:0] addr
   );
      return addr[31:2];
   endfunction

endpackage

// File: rtl/axi_sram_slave.sv
// axi_sram_slave: single-outstanding AXI responder in front
// of a 1-cycle-latency byte-writable data SRAM.
module axi_sram_slave
   import axi_slv_pkg::*;
#(
   parameter int SRAM_AW = 16,
   parameter int ID_W    = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [ID_W-1:0]    s_arid,
   input  logic [31:0]        s_araddr,
   input  logic [2:0]         s_arsize,
   input  logic               s_arvalid,
   output logic               s_arready,
   output logic [ID_W-1:0]    s_rid,
   output logic [31:0]        s_rdata,
   output logic [1:0]         s_rresp,
   output logic               s_rlast,
   output logic               s_rvalid,
   input  logic               s_rready,
   input  logic [ID_W-1:0]    s_awid,
   input  logic [31:0]        s_awaddr,
   input  logic [2:0]         s_awsize,
   input  logic               s_awvalid,
   output logic               s_awready,
   input  logic [31:0]        s_wdata,
   input  logic [3:0]         s_wstrb,
   input  logic               s_wvalid,
   output logic               s_wready,
   output logic [ID_W-1:0]    s_bid,
   output logic [1:0]         s_bresp,
   output logic               s_bvalid,
   input  logic               s_bready,
   output logic               sram_en,
   output logic [3:0]         sram_wen,
   output logic [SRAM_AW-1:0] sram_addr,
   output logic [31:0]        sram_wdata,
   input  logic [31:0]        sram_rdata
);

   state_t               r_state;
   state_t               w_next;
   logic                 w_ar_hs;
   logic                 w_aw_hs;
   logic                 w_w_hs;
   logic                 r_aw_got;
   logic                 r_w_got;
   logic [ID_W-1:0]      r_rid;
   logic [ID_W-1:0]      r_bid;
   logic [31:0]          r_rdata;
   logic [SRAM_AW-1:0]   r_waddr;
   logic [31:0]          r_wdata;
   logic [3:0]           r_wstrb;
   logic [29:0]          w_ar_word;
   logic [29:0]          w_aw_word;
   logic                 w_unused;

   assign w_ar_word = byte_to_word(s_araddr);
   assign w_aw_word = byte_to_word(s_awaddr);

   // Size fields and high address bits alias and are not used.
   assign w_unused = ^{s_arsize, s_awsize,
                       s_araddr[1:0], s_awaddr[1:0],
                       w_ar_word[29:SRAM_AW],
                       w_aw_word[29:SRAM_AW]};

   assign s_rid   = r_rid;
   assign s_rdata = r_rdata;
   assign s_rresp = RESP_OKAY;
   assign s_rlast = s_rvalid;
   assign s_bid   = r_bid;
   assign s_bresp = RESP_OKAY;

   // Next state, channel readies/valids and SRAM strobes.
   always_comb begin
      w_next     = r_state;
      s_arready  = 1'b0;
      s_awready  = 1'b0;
      s_wready   = 1'b0;
      s_rvalid   = 1'b0;
      s_bvalid   = 1'b0;
      w_ar_hs    = 1'b0;
      w_aw_hs    = 1'b0;
      w_w_hs     = 1'b0;
      sram_en    = 1'b0;
      sram_wen   = 4'b0000;
      sram_addr  = '0;
      sram_wdata = '0;
      unique case (r_state)
         ST_IDLE: begin
            s_awready = 1'b1;
            s_wready  = 1'b1;
            // Writes win so a read never overtakes a store.
            s_arready = !s_awvalid && !s_wvalid;
            w_aw_hs   = s_awvalid;
            w_w_hs    = s_wvalid;
            w_ar_hs   = s_arvalid && s_arready;
            if (w_aw_hs && w_w_hs) begin
               w_next = ST_WR_SRAM;
            end else if (w_aw_hs || w_w_hs) begin
               w_next = ST_WR_COLLECT;
            end else if (w_ar_hs) begin
               sram_en   = 1'b1;
               sram_addr = w_ar_word[SRAM_AW-1:0];
               w_next    = ST_RD_DATA;
            end
         end
         ST_RD_DATA: begin
            w_next = ST_R_RESP;
         end
         ST_R_RESP: begin
            s_rvalid = 1'b1;
            if (s_rready) begin
               w_next = ST_IDLE;
            end
         end
         ST_WR_COLLECT: begin
            s_awready = !r_aw_got;
            s_wready  = !r_w_got;
            w_aw_hs   = s_awvalid && s_awready;
            w_w_hs    = s_wvalid && s_wready;
            if (w_aw_hs || w_w_hs) begin
               w_next = ST_WR_SRAM;
            end
         end
         ST_WR_SRAM: begin
            sram_en    = 1'b1;
            sram_wen   = r_wstrb;
            sram_addr  = r_waddr;
            sram_wdata = r_wdata;
            w_next     = ST_B_RESP;
         end
         ST_B_RESP: begin
            s_bvalid = 1'b1;
            if (s_bready) begin
               w_next = ST_IDLE;
            end
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   // State register plus capture of IDs, data and write fields.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state  <= ST_IDLE;
         r_aw_got <= 1'b0;
         r_w_got  <= 1'b0;
         r_rid    <= '0;
         r_bid    <= '0;
         r_rdata  <= '0;
         r_waddr  <= '0;
         r_wdata  <= '0;
         r_wstrb  <= '0;
      end else begin
         r_state <= w_next;
         if (w_ar_hs) begin
            r_rid <= s_arid;
         end
         if (r_state == ST_RD_DATA) begin
            r_rdata <= sram_rdata;
         end
         if (w_aw_hs) begin
            r_waddr  <= w_aw_word[SRAM_AW-1:0];
            r_bid    <= s_awid;
            r_aw_got <= 1'b1;
         end
         if (w_w_hs) begin
            r_wdata <= s_wdata;
            r_wstrb <= s_wstrb;
            r_w_got <= 1'b1;
         end
         if (r_state == ST_WR_SRAM) begin
            r_aw_got <= 1'b0;
            r_w_got  <= 1'b0;
         end
      end
   end

endmodule
